// File: rtl/multicore_io_arbiter_if.sv
// Bundle of sample-dispatch, result-collection and output-stream signals
// shared by the multicore I/O arbiter and its environment.
interface multicore_io_arbiter_if #(
    parameter int N_CORES = 35,
    parameter int IN_W    = 19,
    parameter int OUT_W   = 28,
    parameter int ID_W    = 6
);
    logic signed [IN_W-1:0]      in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_CORES-1:0]          core_req;
    logic [N_CORES-1:0]          core_grant;
    logic signed [IN_W-1:0]      core_in_data;
    logic [N_CORES-1:0]          core_out_en;
    logic [N_CORES*OUT_W-1:0]    core_out_data;
    logic signed [OUT_W-1:0]     out_data;
    logic [ID_W-1:0]             out_id;
    logic                        out_valid;
    logic                        out_ready;
    logic [N_CORES-1:0]          overflow;

    // Arbiter side
    modport slave (
        input  in_data, in_valid, core_req, core_out_en, core_out_data, out_ready,
        output in_ready, core_grant, core_in_data, out_data, out_id, out_valid, overflow
    );

    // Source, sink and core-array side
    modport master (
        output in_data, in_valid, core_req, core_out_en, core_out_data, out_ready,
        input  in_ready, core_grant, core_in_data, out_data, out_id, out_valid, overflow
    );
endinterface

// File: rtl/multicore_io_arbiter.sv
// Round-robin sample dispatch to requesting cores, and round-robin collection of
// per-core results into a tagged, show-ahead output FIFO.
module multicore_io_arbiter #(
    parameter int N_CORES    = 35,
    parameter int IN_W       = 19,
    parameter int OUT_W      = 28,
    parameter int ID_W       = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicore_io_arbiter_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]         id;
        logic signed [OUT_W-1:0] data;
    } entry_t;

    // First set bit of req strictly after ptr, wrapping at N_CORES.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CORES-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= N_CORES; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!found && req[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
        return pick;
    endfunction

    // ---------------- input dispatch ----------------
    logic                   transfer;
    logic [ID_W-1:0]        in_win;
    logic [ID_W-1:0]        in_ptr;
    logic [N_CORES-1:0]     grant_q;
    logic signed [IN_W-1:0] sample_q;

    assign bus.in_ready = |bus.core_req;
    assign transfer     = bus.in_valid && (|bus.core_req);
    assign in_win       = rr_pick(bus.core_req, in_ptr);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            sample_q <= '0;
            in_ptr   <= ID_W'(N_CORES - 1);
        end else if (transfer) begin
            grant_q  <= N_CORES'(1) << in_win;
            sample_q <= bus.in_data;
            in_ptr   <= in_win;
        end else begin
            grant_q  <= '0;
        end
    end

    assign bus.core_grant   = grant_q;
    assign bus.core_in_data = sample_q;

    // ---------------- result capture and drain ----------------
    logic [N_CORES-1:0]      hold_v;
    logic signed [OUT_W-1:0] hold_data [N_CORES];
    logic [N_CORES-1:0]      drained;
    logic [N_CORES-1:0]      capture;
    logic [N_CORES-1:0]      overflow_q;
    logic [ID_W-1:0]         out_ptr;
    logic [ID_W-1:0]         out_win;
    logic                    drain_fire;
    logic                    full;

    assign drain_fire = !full && (|hold_v);
    assign out_win    = rr_pick(hold_v, out_ptr);

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        drained = '0;
        if (drain_fire) drained[out_win] = 1'b1;
    end

    // A slot accepts a new result if empty or being emptied this very cycle.
    assign capture = bus.core_out_en & (~hold_v | drained);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v     <= '0;
            overflow_q <= '0;
            out_ptr    <= ID_W'(N_CORES - 1);
        end else begin
            hold_v     <= (hold_v & ~drained) | capture;
            overflow_q <= overflow_q | (bus.core_out_en & ~capture);
            if (drain_fire) out_ptr <= out_win;
        end
    end

    // NOTE: data storage is left unreset; its valid flags are what reset clears.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (capture[i]) hold_data[i] <= bus.core_out_data[i*OUT_W +: OUT_W];
        end
    end

    assign bus.overflow = overflow_q;

    // ---------------- output FIFO ----------------
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          not_empty;

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign push      = drain_fire;
    assign pop       = not_empty && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{id: out_win, data: hold_data[out_win]};
    end

    // Head is masked while empty so stale storage never shows on the outputs.
    assign head          = mem[rd_ptr];
    assign bus.out_valid = not_empty;
    assign bus.out_data  = not_empty ? head.data : '0;
    assign bus.out_id    = not_empty ? head.id   : '0;

endmodule

// File: tb/tb_multicore_io_arbiter.sv
// Randomised and directed bench for multicore_io_arbiter, compared every cycle
// against a queue-based model of the dispatch/collection rules.
module tb_multicore_io_arbiter;
    localparam int N     = 35;
    localparam int IN_W  = 19;
    localparam int OUT_W = 28;
    localparam int ID_W  = 6;
    localparam int DEPTH = 8;
    localparam logic [N-1:0] ALL_CORES = '1;

    typedef struct {
        int                      id;
        logic signed [OUT_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   dut_pops = 0;

    multicore_io_arbiter_if #(.N_CORES(N), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) bus ();

    multicore_io_arbiter #(
        .N_CORES(N), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                      m_in_ptr;
    int                      m_out_ptr;
    logic [N-1:0]            m_hold_v;
    logic signed [OUT_W-1:0] m_hold_data [N];
    ent_t                    m_fifo [$];
    logic [N-1:0]            m_grant;
    logic signed [IN_W-1:0]  m_cid;
    logic [N-1:0]            m_overflow;

    function automatic int scan(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        m_in_ptr   = N - 1;
        m_out_ptr  = N - 1;
        m_hold_v   = '0;
        m_fifo.delete();
        m_grant    = '0;
        m_cid      = '0;
        m_overflow = '0;
    endtask

    task automatic step_model();
        int   w;
        ent_t e;
        bit   was_full;
        was_full = (m_fifo.size() == DEPTH);
        m_grant = '0;
        if (bus.in_valid && bus.core_req != '0) begin
            w = scan(bus.core_req, m_in_ptr);
            m_grant[w] = 1'b1;
            m_cid      = bus.in_data;
            m_in_ptr   = w;
        end
        if (m_fifo.size() > 0 && bus.out_ready) m_fifo.delete(0);
        if (!was_full && m_hold_v != '0) begin
            w = scan(m_hold_v, m_out_ptr);
            e.id   = w;
            e.data = m_hold_data[w];
            m_fifo.push_back(e);
            m_hold_v[w] = 1'b0;
            m_out_ptr   = w;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.core_out_en[i]) begin
                if (!m_hold_v[i]) begin
                    m_hold_v[i]    = 1'b1;
                    m_hold_data[i] = bus.core_out_data[i*OUT_W +: OUT_W];
                end else begin
                    m_overflow[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset_model();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) reset_model();
            else        step_model();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", bus.in_ready, |bus.core_req);
            check("core_grant", bus.core_grant, m_grant);
            check("core_in_data", bus.core_in_data, m_cid);
            check("out_valid", bus.out_valid, m_fifo.size() > 0);
            if (m_fifo.size() > 0) begin
                check("out_id", bus.out_id, m_fifo[0].id);
                check("out_data", bus.out_data, m_fifo[0].data);
            end else begin
                check("out_id", bus.out_id, 0);
                check("out_data", bus.out_data, 0);
            end
            check("overflow", bus.overflow, m_overflow);
            if (bus.out_valid && bus.out_ready) dut_pops++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_results();
        bus.core_out_en   = '0;
        bus.core_out_data = '0;
    endtask

    task automatic pulse(input int core, input logic signed [OUT_W-1:0] d);
        bus.core_out_en[core]                    = 1'b1;
        bus.core_out_data[core*OUT_W +: OUT_W]   = d;
    endtask

    task automatic drain_all(input int budget);
        clear_results();
        bus.out_ready = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (!bus.out_valid && m_hold_v == '0 && m_fifo.size() == 0) break;
            step();
        end
        check("drain_done", bus.out_valid, 1'b0);
    endtask

    int rr_exp [4] = '{0, 3, 5, 0};

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.core_req  = '0;
        bus.out_ready = 1'b1;
        clear_results();
        repeat (3) step();
        check("reset_grant", bus.core_grant, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_overflow", bus.overflow, 0);
        rst_n = 1'b1;
        step();

        // Round-robin dispatch over cores 0, 3, 5.
        bus.core_req[0] = 1'b1;
        bus.core_req[3] = 1'b1;
        bus.core_req[5] = 1'b1;
        bus.in_valid    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_data = IN_W'(100 + k);
            step();
            check("rr_grant", bus.core_grant, N'(1) << rr_exp[k]);
            check("rr_data", bus.core_in_data, 100 + k);
            check("rr_model_grant", m_grant, N'(1) << rr_exp[k]);
        end
        bus.core_req = '0;
        #1;
        check("idle_in_ready", bus.in_ready, 0);
        step();
        check("idle_grant", bus.core_grant, 0);
        check("idle_data_hold", bus.core_in_data, 103);
        bus.in_valid = 1'b0;

        // Three results in one cycle, drained in core order.
        pulse(1, -5);
        pulse(2, 7);
        pulse(34, 134217727);
        step();
        clear_results();
        check("sim_t1_valid", bus.out_valid, 0);
        step();
        check("sim_valid", bus.out_valid, 1);
        check("sim_id0", bus.out_id, 1);
        check("sim_d0", bus.out_data, -5);
        step();
        check("sim_id1", bus.out_id, 2);
        check("sim_d1", bus.out_data, 7);
        step();
        check("sim_id2", bus.out_id, 34);
        check("sim_d2", bus.out_data, 134217727);
        step();
        check("sim_empty", bus.out_valid, 0);

        // Recapture on core 4 in the cycle its held result drains.
        pulse(4, 1111);
        step();
        pulse(4, 2222);
        step();
        clear_results();
        check("recap_id_a", bus.out_id, 4);
        check("recap_d_a", bus.out_data, 1111);
        step();
        check("recap_id_b", bus.out_id, 4);
        check("recap_d_b", bus.out_data, 2222);
        check("recap_ovf4", bus.overflow[4], 0);
        drain_all(50);

        // Backpressure: every core pulses every other cycle into a stalled sink.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            clear_results();
            if (c % 2 == 0) begin
                for (int i = 0; i < N; i++) pulse(i, OUT_W'($urandom));
            end
            step();
        end
        clear_results();
        check("bp_valid", bus.out_valid, 1);
        check("bp_overflow", bus.overflow, ALL_CORES);
        check("bp_model_fill", m_fifo.size(), DEPTH);
        drain_all(200);

        // Twenty single results against a sink ready every other cycle.
        dut_pops = 0;
        for (int k = 0; k < 20; k++) begin
            clear_results();
            bus.out_ready = k[0];
            pulse((k * 3) % N, OUT_W'($urandom));
            step();
        end
        drain_all(200);
        check("wrap_count", dut_pops, 20);

        // Random traffic on both sides.
        for (int c = 0; c < 2000; c++) begin
            clear_results();
            bus.core_req  = ($urandom_range(0, 3) == 0) ? '0 : N'({$urandom, $urandom});
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_data   = IN_W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) pulse($urandom_range(0, N - 1), OUT_W'($urandom));
            if ($urandom_range(0, 7) == 0) pulse($urandom_range(0, N - 1), OUT_W'($urandom));
            step();
        end

        // Asynchronous reset in the middle of activity.
        rst_n = 1'b0;
        #1;
        check("arst_grant", bus.core_grant, 0);
        check("arst_data", bus.core_in_data, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_out_id", bus.out_id, 0);
        check("arst_overflow", bus.overflow, 0);
        clear_results();
        bus.in_valid = 1'b0;
        repeat (2) step();
        rst_n        = 1'b1;
        bus.core_req = ALL_CORES;
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(5);
        step();
        check("post_reset_grant", bus.core_grant, 1);
        check("post_reset_data", bus.core_in_data, 5);
        bus.in_valid = 1'b0;
        bus.core_req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
